// File: rtl/larpix_fifo_pkg.sv
// Shared types and defaults for the event FIFO acceptor.
// Holds the write-handshake FSM encoding and the default geometry.
package larpix_fifo_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_DEPTH = 2048;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        ACK      = 2'd2,
        WAIT_LOW = 2'd3
    } wr_state_e;

endpackage

// File: rtl/event_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Read data holds its last value when no read is issued.
module event_fifo_ram #(
    parameter int WIDTH = 64,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/event_fifo_acceptor.sv
// Router-facing FIFO acceptor with FWFT output; EVENT_FIFO_HWM_EN adds
// a high-water-mark port with its clear input.
module event_fifo_acceptor
    import larpix_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int FIFO_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_event,
    input  logic [WIDTH-1:0]     channel_event_in,
    output logic                 fifo_ack,
    output logic [WIDTH-1:0]     data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 fifo_full,
    output logic                 fifo_half,
    output logic                 fifo_empty,
    output logic [FIFO_BITS:0]   fifo_counter
`ifdef EVENT_FIFO_HWM_EN
    ,
    input  logic                 clear_high_water,
    output logic [FIFO_BITS:0]   fifo_high_water
`endif
);

    localparam int CW = FIFO_BITS + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    wr_state_e         state_q, state_d;
    logic [CW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, half_q, empty_q;
    logic              pf_valid_q, pf_valid_d;
    logic              out_valid_q;
    logic [WIDTH-1:0]  out_q, ram_rdata;
    logic              wr_en, rd_en, pop, out_load, ram_has_data;

    assign wr_en        = (state_q == WRITE);
    assign pop          = out_valid_q & data_ready;
    assign out_load     = pf_valid_q & (~out_valid_q | pop);
    assign ram_has_data = (wr_ptr_q != rd_ptr_q);
    // Refill the prefetch slot whenever it is empty or moving on.
    assign rd_en        = ram_has_data & (~pf_valid_q | out_load);
    assign pf_valid_d   = rd_en | (pf_valid_q & ~out_load);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (load_event && !full_q) state_d = WRITE;
            WRITE:    state_d = ACK;
            ACK:      state_d = WAIT_LOW;
            WAIT_LOW: if (!load_event) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    event_fifo_ram #(
        .WIDTH (WIDTH),
        .AW    (FIFO_BITS)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en & ~reset),
        .waddr_i (wr_ptr_q[FIFO_BITS-1:0]),
        .wdata_i (channel_event_in),
        .re_i    (rd_en & ~reset),
        .raddr_i (rd_ptr_q[FIFO_BITS-1:0]),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            half_q      <= 1'b0;
            empty_q     <= 1'b1;
            pf_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            full_q     <= (count_d == CW'(DEPTH));
            half_q     <= (count_d >= CW'(DEPTH / 2));
            empty_q    <= (count_d == '0);
            pf_valid_q <= pf_valid_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + ONE;
            if (rd_en) rd_ptr_q <= rd_ptr_q + ONE;
            if (out_load) begin
                out_q       <= ram_rdata;
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef EVENT_FIFO_HWM_EN
    logic [CW-1:0] hwm_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hwm_q <= '0;
        end else if (clear_high_water) begin
            hwm_q <= count_q;
        end else if (count_q > hwm_q) begin
            hwm_q <= count_q;
        end
    end

    assign fifo_high_water = hwm_q;
`endif

    assign fifo_ack     = (state_q == ACK);
    assign data_out     = out_q;
    assign data_valid   = out_valid_q;
    assign fifo_full    = full_q;
    assign fifo_half    = half_q;
    assign fifo_empty   = empty_q;
    assign fifo_counter = count_q;

endmodule

// File: tb/tb_event_fifo_acceptor.sv
// Directed bench for event_fifo_acceptor with an in-order scoreboard.
// Uses a shallow FIFO so full, half and pointer wrap are reachable.
module tb_event_fifo_acceptor;

    localparam int W  = 64;
    localparam int D  = 8;
    localparam int FB = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_event = 1'b0;
    logic [W-1:0]  channel_event_in = '0;
    logic          fifo_ack;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic          data_ready = 1'b0;
    logic          fifo_full, fifo_half, fifo_empty;
    logic [FB:0]   fifo_counter;
`ifdef EVENT_FIFO_HWM_EN
    logic          clear_high_water = 1'b0;
    logic [FB:0]   fifo_high_water;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb [$];

    always #5 clk = ~clk;

    event_fifo_acceptor #(
        .WIDTH     (W),
        .DEPTH     (D),
        .FIFO_BITS (FB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .load_event       (load_event),
        .channel_event_in (channel_event_in),
        .fifo_ack         (fifo_ack),
        .data_out         (data_out),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .fifo_full        (fifo_full),
        .fifo_half        (fifo_half),
        .fifo_empty       (fifo_empty),
        .fifo_counter     (fifo_counter)
`ifdef EVENT_FIFO_HWM_EN
        ,
        .clear_high_water (clear_high_water),
        .fifo_high_water  (fifo_high_water)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every pop must match the oldest accepted word.
    always @(negedge clk) begin
        if (!reset && data_valid && data_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) chk("data_order", data_out, sb.pop_front());
        end
    end

    task automatic send(input logic [W-1:0] w, input bit pop_at_write,
                        output bit acked);
        cyc();
        load_event = 1'b1;
        channel_event_in = w;
        acked = 1'b0;
        if (pop_at_write) begin
            cyc();
            data_ready = 1'b1;
            cyc();
            data_ready = 1'b0;
        end
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (fifo_ack) acked = 1'b1;
        end
        if (acked) sb.push_back(w);
        cyc();
        load_event = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        cyc();
        data_ready = 1'b1;
        for (int i = 0; i < 4 * D + 8 && !done; i++) begin
            @(negedge clk);
            if (fifo_empty) done = 1'b1;
        end
        cyc();
        data_ready = 1'b0;
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_cnt"}, 64'(fifo_counter), 64'd0);
        chk({tag, "_sb"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           ok;
        int           acks;
        logic [W-1:0] w;

        // Reset state
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_ack", 64'(fifo_ack), 64'd0);
        chk("rst_valid", 64'(data_valid), 64'd0);
        chk("rst_data", data_out, 64'd0);
        chk("rst_full", 64'(fifo_full), 64'd0);
        chk("rst_half", 64'(fifo_half), 64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        chk("rst_cnt", 64'(fifo_counter), 64'd0);
        cyc();
        reset = 1'b0;

        // Single event: ack two edges after load is seen
        w = 64'h0123_4567_89AB_CDEF;
        cyc();
        load_event = 1'b1;
        channel_event_in = w;
        @(negedge clk);
        chk("t1_ack_idle", 64'(fifo_ack), 64'd0);
        @(negedge clk);
        chk("t1_ack_write", 64'(fifo_ack), 64'd0);
        @(negedge clk);
        chk("t1_ack_pulse", 64'(fifo_ack), 64'd1);
        chk("t1_cnt", 64'(fifo_counter), 64'd1);
        chk("t1_empty", 64'(fifo_empty), 64'd0);
        sb.push_back(w);
        cyc();
        load_event = 1'b0;
        @(negedge clk);
        chk("t1_ack_after", 64'(fifo_ack), 64'd0);
        chk("t1_valid_early", 64'(data_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid", 64'(data_valid), 64'd1);
        chk("t1_data", data_out, w);
        drain("t1_drain");

        // Held request yields one ack; re-raise yields another
        w = 64'hA5A5_0000_1111_2222;
        cyc();
        load_event = 1'b1;
        channel_event_in = w;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (fifo_ack) acks++;
        end
        chk("held_acks", 64'(acks), 64'd1);
        chk("held_cnt", 64'(fifo_counter), 64'd1);
        sb.push_back(w);
        cyc();
        load_event = 1'b0;
        w = 64'h5A5A_3333_4444_5555;
        cyc();
        load_event = 1'b1;
        channel_event_in = w;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (fifo_ack) acks++;
        end
        chk("reraise_acks", 64'(acks), 64'd1);
        chk("reraise_cnt", 64'(fifo_counter), 64'd2);
        sb.push_back(w);
        cyc();
        load_event = 1'b0;
        drain("t2_drain");

        // Fill to full with the consumer stalled
        for (int i = 0; i < D; i++) begin
            w = {$urandom, $urandom};
            send(w, 1'b0, ok);
            chk("fill_ack", 64'(ok), 64'd1);
            chk("fill_cnt", 64'(fifo_counter), 64'(i + 1));
            chk("fill_half", 64'(fifo_half), 64'(i + 1 >= D / 2));
            chk("fill_full", 64'(fifo_full), 64'(i + 1 == D));
        end
        w = 64'hDEAD_BEEF_CAFE_F00D;
        cyc();
        load_event = 1'b1;
        channel_event_in = w;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (fifo_ack) acks++;
        end
        chk("full_no_ack", 64'(acks), 64'd0);
        chk("full_hold", 64'(fifo_full), 64'd1);
        cyc();
        data_ready = 1'b1;
        cyc();
        data_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (fifo_ack) ok = 1'b1;
        end
        chk("resume_ack", 64'(ok), 64'd1);
        chk("resume_cnt", 64'(fifo_counter), 64'(D));
        if (ok) sb.push_back(w);
        cyc();
        load_event = 1'b0;
        drain("t3_drain");

        // Write and pop in the same cycle across several wraps
        for (int i = 0; i < 3; i++) begin
            send({$urandom, $urandom}, 1'b0, ok);
            chk("pre_ack", 64'(ok), 64'd1);
        end
        for (int i = 0; i < 3 * D; i++) begin
            send({$urandom, $urandom}, 1'b1, ok);
            chk("conc_ack", 64'(ok), 64'd1);
            chk("conc_cnt", 64'(fifo_counter), 64'd3);
        end
        drain("t4_drain");

        // Reset while in ACK
        for (int i = 0; i < 2; i++) begin
            send({$urandom, $urandom}, 1'b0, ok);
        end
        w = 64'h0F0F_0F0F_F0F0_F0F0;
        cyc();
        load_event = 1'b1;
        channel_event_in = w;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (fifo_ack) ok = 1'b1;
        end
        chk("rsta_seen", 64'(ok), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rsta_ack", 64'(fifo_ack), 64'd0);
        chk("rsta_cnt", 64'(fifo_counter), 64'd0);
        chk("rsta_empty", 64'(fifo_empty), 64'd1);
        chk("rsta_valid", 64'(data_valid), 64'd0);
        cyc();
        reset = 1'b0;
        load_event = 1'b0;
        sb.delete();
        w = 64'h1234_5678_9ABC_DEF0;
        send(w, 1'b0, ok);
        chk("post_rst_ack", 64'(ok), 64'd1);
        chk("post_rst_cnt", 64'(fifo_counter), 64'd1);
        drain("t5_drain");

`ifdef EVENT_FIFO_HWM_EN
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send({$urandom, $urandom}, 1'b0, ok);
        end
        drain("hwm_drain");
        cyc();
        chk("hwm_peak", 64'(fifo_high_water), 64'd6);
        clear_high_water = 1'b1;
        cyc();
        clear_high_water = 1'b0;
        chk("hwm_clear", 64'(fifo_high_water), 64'd0);
`endif

        chk("final_sb", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
